keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_TICKS, default 100000, gives the mclk cycles each column is driven (1 ms at 100 MHz); the minimum legal value SHALL be 4.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4, gives the consecutive identical frames needed to accept a press or a release; the minimum legal value SHALL be 1.
REQ-003 mclk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 row  input  4  keypad row lines, active-low with external pull-ups, asynchronous to mclk.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 key_code  output  4  hex value of the accepted key, held until the next accepted press.
REQ-008 key_valid  output  1  one-cycle pulse on acceptance of a press.
REQ-009 key_held  output  1  high from acceptance of a press until acceptance of its release.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before any use.
REQ-011 A tick counter SHALL count 0..SCAN_TICKS-1 and wrap to 0; at the wrap the active column SHALL advance 0->1->2->3->0 (col 1110->1101->1011->0111->1110).
REQ-012 The synchronized rows SHALL be sampled on the cycle where tick == SCAN_TICKS-1, i.e. the last cycle of the column dwell.
REQ-013 A frame SHALL be the four samples of columns 0..3, evaluated on the column-3 sample cycle.
REQ-014 A frame result SHALL be a candidate only if exactly one key reads low across the frame; zero keys or two or more keys SHALL count as "none".
REQ-015 Keymap, listed as (row, col0..col3): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = 0 F E D.
REQ-016 The FSM SHALL have the states IDLE, DEBOUNCE, PRESSED and RELEASE; transitions SHALL occur only on frame-evaluation cycles.
REQ-017 IDLE: a candidate SHALL be stored, the frame count set to 1, and the FSM moved to DEBOUNCE; if DEBOUNCE_FRAMES==1 the FSM SHALL go directly to PRESSED.
REQ-018 DEBOUNCE: the same candidate SHALL increment the count; on reaching DEBOUNCE_FRAMES the FSM SHALL enter PRESSED. A different candidate SHALL restart the count at 1 with the new candidate. "None" SHALL return the FSM to IDLE.
REQ-019 On entry to PRESSED, key_code SHALL load the candidate in the same cycle that key_valid pulses high; key_held SHALL rise in that cycle.
REQ-020 PRESSED: any frame not matching the latched key SHALL move the FSM to RELEASE with the count at 1, or straight to IDLE if DEBOUNCE_FRAMES==1.
REQ-021 RELEASE: a frame matching the latched key SHALL return the FSM to PRESSED with no key_valid pulse. Otherwise the count SHALL increment; on reaching DEBOUNCE_FRAMES the FSM SHALL enter IDLE and key_held SHALL fall in that cycle.
REQ-022 Latency from a stable press to key_valid SHALL be at most (DEBOUNCE_FRAMES+1)*4*SCAN_TICKS+3 cycles.
REQ-023 Counter widths SHALL be ceil(log2) of their parameter; no counter may overflow.

Reset
REQ-024 While rst is high: col=1110, tick=0, column index=0, FSM=IDLE, frame count=0, key_code=0, key_valid=0, key_held=0, and synchronizer flops all-ones.
REQ-025 Reset asserted mid-press SHALL abort the operation with no key_valid pulse; after deassertion, scanning SHALL restart at column 0 and tick 0.

Structure
REQ-026 Package keypad_pkg SHALL hold the FSM state enumeration, the 16-entry keymap constant, and the parameter defaults.
REQ-027 The row synchronizer SHALL be a separate sub-module sync2 (4 bits wide, reset to all-ones); everything else SHALL reside in keypad_scan.

Verification (SCAN_TICKS=4, DEBOUNCE_FRAMES=2, keypad model drives row low when its column is low)
REQ-028 Reset release, no key: col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never rises; key_code=0.
REQ-029 Hold key (r2,c1) for 5 frames: exactly one key_valid pulse with key_code=8; key_held high until 2 frames after release.
REQ-030 Press (r3,c2) for 1 frame, then none: no key_valid; FSM returns to IDLE.
REQ-031 Hold (r0,c3) and (r1,c0) together for 4 frames: no key_valid. Then release (r1,c0): one key_valid with key_code=A.
REQ-032 Hold key 5 until PRESSED, drop it for 1 frame, restore for 3 frames: single key_valid, key_held never falls.
REQ-033 Assert rst during DEBOUNCE of key F: all outputs reach their reset values immediately; no key_valid; scanning restarts at 1110.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, defaults and the key lookup table for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned SCAN_TICKS_DEF      = 100000;
  localparam int unsigned DEBOUNCE_FRAMES_DEF = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StPressed,
    StRelease
  } key_state_e;

  // Entry {row, col} holds the hex code of that key; entry 0 sits in the low nibble.
  localparam logic [63:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    return KEYMAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines; resets to all-ones (idle rows).
module sync2 #(
  parameter int unsigned Width = 4
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with frame-based debounce and single-key press/release detection.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS      = SCAN_TICKS_DEF,
  parameter int unsigned DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned TickW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned CntW  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(SCAN_TICKS - 1);
  localparam logic [CntW-1:0]  CntDone  = CntW'(DEBOUNCE_FRAMES);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);

  logic [3:0]       row_s;
  logic [TickW-1:0] tick_q;
  logic [1:0]       col_idx_q;
  logic [11:0]      samp_q;
  key_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic             sample_en;
  logic             frame_eval;
  logic [15:0]      frame_low;
  logic [4:0]       n_low;
  logic [3:0]       hit_idx;
  logic             cand_ok;
  logic [3:0]       cand_code;
  logic             match_held;
  logic [CntW-1:0]  cnt_inc;

  sync2 #(
    .Width(4)
  ) u_row_sync (
    .mclk(mclk),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  assign sample_en  = (tick_q == TickLast);
  assign frame_eval = sample_en && (col_idx_q == 2'd3);
  assign col        = ~(4'b0001 << col_idx_q);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      tick_q    <= '0;
      col_idx_q <= 2'd0;
      samp_q    <= '1;
    end else if (sample_en) begin
      tick_q    <= '0;
      col_idx_q <= col_idx_q + 2'd1;
      // Column 3 is never stored: it is consumed live on the evaluation cycle.
      if (col_idx_q != 2'd3) begin
        samp_q[{col_idx_q, 2'b00} +: 4] <= row_s;
      end
    end else begin
      tick_q <= tick_q + TickW'(1);
    end
  end

  // Frame bit 4*col+row is low when that key conducts.
  assign frame_low = ~{row_s, samp_q};

  always_comb begin
    n_low   = 5'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_low[i]) begin
        n_low   = n_low + 5'd1;
        hit_idx = {i[1:0], i[3:2]};
      end
    end
  end

  assign cand_ok    = (n_low == 5'd1);
  assign cand_code  = key_lookup(hit_idx);
  assign match_held = cand_ok && (cand_code == key_code_q);
  assign cnt_inc    = cnt_q + CntOne;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (frame_eval) begin
      unique case (state_q)
        StIdle: begin
          if (cand_ok) begin
            cand_d = cand_code;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d     = StPressed;
              cnt_d       = '0;
              key_code_d  = cand_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = StDebounce;
              cnt_d   = CntOne;
            end
          end
        end
        StDebounce: begin
          if (!cand_ok) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cand_code == cand_q) begin
            if (cnt_inc == CntDone) begin
              state_d     = StPressed;
              cnt_d       = '0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cand_d = cand_code;
            cnt_d  = CntOne;
          end
        end
        StPressed: begin
          if (!match_held) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d    = StIdle;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              state_d = StRelease;
              cnt_d   = CntOne;
            end
          end
        end
        StRelease: begin
          if (match_held) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_inc == CntDone) begin
            state_d    = StIdle;
            cnt_d      = '0;
            key_held_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Frame-level self-checking bench for keypad_scan with a simulated keypad and debounce model.
module tb_keypad_scan;

  localparam int ST = 4;
  localparam int DF = 2;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'h0000;  // bit r*4+c = key at (row r, col c)

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  logic [3:0]  ref_key [16];
  bit          m_held;
  logic [3:0]  m_code;
  logic [3:0]  prev;
  int          run;
  int          miss;

  always #5 mclk = ~mclk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  keypad_scan #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .mclk     (mclk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0;
    m_code = 4'h0;
    prev   = 4'h0;
    run    = 0;
    miss   = 0;
  endtask

  function automatic void reading(input logic [15:0] m, output bit ok, output logic [3:0] code);
    ok   = ($countones(m) == 1);
    code = 4'h0;
    for (int b = 0; b < 16; b++) if (m[b]) code = ref_key[b];
  endfunction

  // One frame of the debounce rules, applied to the key set held during that frame.
  task automatic model_frame(input logic [15:0] m, output bit exp_v);
    bit         ok;
    logic [3:0] code;
    reading(m, ok, code);
    exp_v = 1'b0;
    if (!m_held) begin
      if (!ok) run = 0;
      else if (run > 0 && code == prev) run++;
      else begin
        run  = 1;
        prev = code;
      end
      if (run == DF) begin
        exp_v  = 1'b1;
        m_code = prev;
        m_held = 1'b1;
        run    = 0;
        miss   = 0;
      end
    end else begin
      if (ok && code == m_code) miss = 0;
      else begin
        miss++;
        if (miss == DF) begin
          m_held = 1'b0;
          miss   = 0;
        end
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] m, input string tag);
    bit         exp_v;
    logic [3:0] exp_col;
    pressed = m;
    for (int k = 0; k < 4 * ST; k++) begin
      @(posedge mclk);
      #1;
      cyc++;
      exp_col = 4'hF & ~(4'h1 << ((cyc / ST) % 4));
      check({tag, ".col"}, col, exp_col);
      if (k == 4 * ST - 1) model_frame(m, exp_v);
      else exp_v = 1'b0;
      check({tag, ".valid"}, 4'(key_valid), 4'(exp_v));
      check({tag, ".held"}, 4'(key_held), 4'(m_held));
      check({tag, ".code"}, key_code, m_code);
    end
  endtask

  task automatic release_reset();
    @(negedge mclk);
    rst = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  initial begin
    ref_key = '{4'h1, 4'h2, 4'h3, 4'hA,
                4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC,
                4'h0, 4'hF, 4'hE, 4'hD};
    model_reset();

    repeat (3) @(posedge mclk);
    #1;
    check("rst.col", col, 4'b1110);
    check("rst.code", key_code, 4'h0);
    check("rst.valid", 4'(key_valid), 4'h0);
    check("rst.held", 4'(key_held), 4'h0);
    release_reset();

    repeat (2) run_frame(16'h0000, "idle");

    repeat (5) run_frame(16'h0001 << 9, "key8");
    repeat (3) run_frame(16'h0000, "key8rel");

    run_frame(16'h0001 << 14, "glitchE");
    repeat (2) run_frame(16'h0000, "glitchE.none");

    repeat (4) run_frame((16'h0001 << 3) | (16'h0001 << 4), "dual");
    repeat (3) run_frame(16'h0001 << 3, "keyA");
    repeat (3) run_frame(16'h0000, "keyA.rel");

    repeat (2) run_frame(16'h0001 << 5, "key5");
    run_frame(16'h0000, "key5.drop");
    repeat (3) run_frame(16'h0001 << 5, "key5.back");
    repeat (3) run_frame(16'h0000, "key5.rel");

    // Reset in the middle of debouncing key F.
    run_frame(16'h0001 << 13, "keyF");
    pressed = 16'h0001 << 13;
    repeat (7) begin
      @(posedge mclk);
      #1;
      check("keyF.pre.valid", 4'(key_valid), 4'h0);
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst.col", col, 4'b1110);
    check("midrst.code", key_code, 4'h0);
    check("midrst.valid", 4'(key_valid), 4'h0);
    check("midrst.held", 4'(key_held), 4'h0);
    pressed = 16'h0000;
    repeat (2) begin
      @(posedge mclk);
      #1;
      check("midrst.hold.col", col, 4'b1110);
      check("midrst.hold.valid", 4'(key_valid), 4'h0);
    end
    release_reset();
    repeat (2) run_frame(16'h0000, "postrst");

    for (int it = 0; it < 30; it++) begin
      logic [15:0] m;
      int          kind;
      int          a;
      int          b;
      kind = $urandom_range(0, 3);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      case (kind)
        0:       m = 16'h0000;
        1:       m = 16'h0001 << a;
        2:       m = (16'h0001 << a) | (16'h0001 << b);
        default: m = pressed;
      endcase
      repeat ($urandom_range(1, 4)) run_frame(m, "rand");
    end
    repeat (3) run_frame(16'h0000, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
